// File: rtl/decoder_pkg.sv
// Shared constants for the decoder_pipe block: occupancy state encoding and
// the width of the accepted-token counter.
package decoder_pkg;

    // Occupancy of the two-entry output buffer (main entry + skid entry).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/decoder_onehot.sv
// Purely combinational SEL_W-to-NUM_OUT one-hot decoder.
// Ports:
//   en_i       : 0 = null token, decodes to all-zero with no error
//   sel_i      : select index
//   onehot_c_o : bit sel_i set when en_i=1 and sel_i < NUM_OUT
//   err_c_o    : en_i=1 and sel_i >= NUM_OUT (onehot is then all-zero)
module decoder_onehot #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 4
) (
    input  logic               en_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [NUM_OUT-1:0] onehot_c_o,
    output logic               err_c_o
);

    // One comparator per output line; out-of-range selects match no line.
    always_comb begin
        onehot_c_o = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            onehot_c_o[i] = en_i && (sel_i == SEL_W'(i));
        end
    end

    // A fully populated decoder cannot see an out-of-range select.
    if (NUM_OUT == (2 ** SEL_W)) begin : g_full
        assign err_c_o = 1'b0;
    end else begin : g_part
        localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_OUT);
        assign err_c_o = en_i && ({1'b0, sel_i} >= LIMIT);
    end

endmodule

// File: rtl/decoder_pipe.sv
// Registered one-hot decoder with valid/ready on both sides and a 2-entry
// (main + skid) buffer so the input side keeps full throughput under
// backpressure without in_ready depending on out_ready.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : input handshake (in_ready is a flop)
//   in_sel, in_en      : token select index and enable (0 = null token)
//   out_valid/out_ready: output handshake
//   out_onehot, out_sel, out_err : decoded token held until delivered
//   tok_count          : accepted-token count, saturating
// Build option: DECODER_PIPE_COUNT_EN enables the token counter; without it
// tok_count is tied to zero and no counter flops exist.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_err,
    output logic [CNT_W-1:0]   tok_count
);

    logic [NUM_OUT-1:0] dec_onehot_c;
    logic               dec_err_c;
    logic               accept_c;
    logic               deliver_c;

    occ_e               state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0] main_onehot_q, main_onehot_d;
    logic [SEL_W-1:0]   main_sel_q, main_sel_d;
    logic               main_err_q, main_err_d;
    logic [NUM_OUT-1:0] skid_onehot_q, skid_onehot_d;
    logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
    logic               skid_err_q, skid_err_d;

    // Decode once, on the input path; the stored result is never recomputed.
    decoder_onehot #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_onehot (
        .en_i       (in_en),
        .sel_i      (in_sel),
        .onehot_c_o (dec_onehot_c),
        .err_c_o    (dec_err_c)
    );

    assign accept_c  = in_valid && in_ready_q;
    assign deliver_c = out_valid_q && out_ready;

    // Occupancy next-state and buffer loads.
    always_comb begin
        state_d       = state_q;
        main_onehot_d = main_onehot_q;
        main_sel_d    = main_sel_q;
        main_err_d    = main_err_q;
        skid_onehot_d = skid_onehot_q;
        skid_sel_d    = skid_sel_q;
        skid_err_d    = skid_err_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    main_onehot_d = dec_onehot_c;
                    main_sel_d    = in_sel;
                    main_err_d    = dec_err_c;
                    state_d       = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && deliver_c) begin
                    // Main is reloaded on the same edge it drains: no bubble.
                    main_onehot_d = dec_onehot_c;
                    main_sel_d    = in_sel;
                    main_err_d    = dec_err_c;
                end else if (accept_c) begin
                    skid_onehot_d = dec_onehot_c;
                    skid_sel_d    = in_sel;
                    skid_err_d    = dec_err_c;
                    state_d       = ST_TWO;
                end else if (deliver_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver_c) begin
                    main_onehot_d = skid_onehot_q;
                    main_sel_d    = skid_sel_q;
                    main_err_d    = skid_err_q;
                    state_d       = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Handshake flags follow the next occupancy so they are plain flops.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            main_onehot_q <= '0;
            main_sel_q    <= '0;
            main_err_q    <= 1'b0;
            skid_onehot_q <= '0;
            skid_sel_q    <= '0;
            skid_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            main_onehot_q <= main_onehot_d;
            main_sel_q    <= main_sel_d;
            main_err_q    <= main_err_d;
            skid_onehot_q <= skid_onehot_d;
            skid_sel_q    <= skid_sel_d;
            skid_err_q    <= skid_err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = main_onehot_q;
    assign out_sel    = main_sel_q;
    assign out_err    = main_err_q;

`ifdef DECODER_PIPE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of accepted tokens, null tokens included.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tok_count = cnt_q;
`else
    assign tok_count = '0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe (SEL_W=3, NUM_OUT=5 so both the
// MSB boundary and the out-of-range error path are reachable).
// The reference is a token queue: accepted tokens are decoded arithmetically
// and pushed, delivered tokens popped; the DUT must show the queue head.
module tb_decoder_pipe;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned NUM_OUT = 5;

    typedef struct {
        logic [NUM_OUT-1:0] onehot;
        logic [SEL_W-1:0]   sel;
        logic               err;
    } tok_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               in_en;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] out_onehot;
    logic [SEL_W-1:0]   out_sel;
    logic               out_err;
    logic [15:0]        tok_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    tok_t mq[$];
    int   mcnt = 0;

    always #5 clk = ~clk;

    decoder_pipe #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_sel    (out_sel),
        .out_err    (out_err),
        .tok_count  (tok_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic tok_t ref_decode(input logic [SEL_W-1:0] s, input logic e);
        tok_t t;
        int   idx;
        idx      = int'(s);
        t.sel    = s;
        t.onehot = '0;
        t.err    = 1'b0;
        if (e) begin
            if (idx < NUM_OUT) t.onehot = NUM_OUT'(1 << idx);
            else               t.err    = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef DECODER_PIPE_COUNT_EN
        return 32'(mcnt);
`else
        return 32'd0;
`endif
    endfunction

    // Apply one cycle of stimulus, check DUT state against the model, then
    // advance the model by the handshakes that happen at the next edge.
    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic e, input logic r);
        logic acc, del;
        in_valid  = v;
        in_sel    = s;
        in_en     = e;
        out_ready = r;
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check_eq("in_ready",  32'(in_ready),  32'(mq.size() < 2));
        if (mq.size() != 0) begin
            check_eq("out_onehot", 32'(out_onehot), 32'(mq[0].onehot));
            check_eq("out_sel",    32'(out_sel),    32'(mq[0].sel));
            check_eq("out_err",    32'(out_err),    32'(mq[0].err));
        end
        check_eq("tok_count", 32'(tok_count), exp_count());
        acc = v && (mq.size() < 2);
        del = (mq.size() != 0) && r;
        @(posedge clk);
        #1;
        if (del) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(ref_decode(s, e));
            if (mcnt < 16'hFFFF) mcnt++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        mq.delete();
        mcnt = 0;
        check_eq("rst_out_valid", 32'(out_valid),  32'd0);
        check_eq("rst_in_ready",  32'(in_ready),   32'd1);
        check_eq("rst_onehot",    32'(out_onehot), 32'd0);
        check_eq("rst_sel",       32'(out_sel),    32'd0);
        check_eq("rst_err",       32'(out_err),    32'd0);
        check_eq("rst_count",     32'(tok_count),  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_en     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Single token: visible one clock after accept.
        step(1'b1, 3'd2, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);

        // Back-to-back stream across every in-range select.
        for (int i = 0; i < NUM_OUT; i++) step(1'b1, SEL_W'(i), 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);

        // Backpressure: fill main and skid, then drain in order.
        step(1'b1, 3'd1, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd4, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);

        // Boundaries: MSB select, out-of-range selects, null token.
        step(1'b1, 3'd4, 1'b1, 1'b1);
        step(1'b1, 3'd6, 1'b1, 1'b1);
        step(1'b1, 3'd5, 1'b1, 1'b1);
        step(1'b1, 3'd7, 1'b1, 1'b1);
        step(1'b1, 3'd1, 1'b0, 1'b1);
        step(1'b1, 3'd6, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b1, 1'b1);

        // Reset while both entries are full: nothing stale may come out.
        step(1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b1, 3'd2, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0);
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b1, 1'b1);

        // Randomized traffic with random backpressure and a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 3) != 0,
                 SEL_W'($urandom_range(0, 7)),
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0);
        end

        // Drain whatever is left.
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
